// File: rtl/mesh_pkg.sv
// Shared types for the mesh router allocator.
// Port order is c,n,e,s,w; vectors are indexed [0:4] in that order.
package mesh_pkg;

  localparam int N_PORTS = 5;

  typedef enum logic [2:0] {
    PORT_C,
    PORT_N,
    PORT_E,
    PORT_S,
    PORT_W
  } port_e;

  typedef logic [0:N_PORTS-1] port_vec_t;

  typedef enum logic {
    ALLOC_IDLE,
    ALLOC_BUSY
  } alloc_state_e;

  function automatic logic [2:0] next_port(
    input logic [2:0] p
  );
    return (p == 3'd4) ? 3'd0 : p + 3'd1;
  endfunction

endpackage

// File: rtl/mesh_rr_arbiter.sv
// 5-way round-robin arbiter: first requester
// at or after ptr (mod 5) wins.
import mesh_pkg::*;

module mesh_rr_arbiter (
  input  port_vec_t  req,
  input  logic [2:0] ptr,
  output port_vec_t  gnt,
  output logic [2:0] winner,
  output logic       valid
);

  logic [3:0] idx;

  always_comb begin
    gnt    = '0;
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= 4'd5) idx = idx - 4'd5;
      if (!valid && req[idx[2:0]]) begin
        valid  = 1'b1;
        winner = idx[2:0];
      end
    end
    if (valid) gnt[winner] = 1'b1;
  end

endmodule

// File: rtl/mesh_switch_allocator.sv
// Mesh switch allocator: per-output round-robin with wormhole lock.
// Optional per-output grant counters with MESH_ALLOC_STATS_EN.
import mesh_pkg::*;

module mesh_switch_allocator #(
  parameter int STAT_WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [0:4][0:4]  i_output_req,
  input  logic [0:4]       i_tail,
  input  logic [0:4]       i_output_en,
  output logic [0:4]       o_input_grant,
  output logic [0:4][0:4]  o_xbar_sel
`ifdef MESH_ALLOC_STATS_EN
  ,
  output logic [0:4][STAT_WIDTH-1:0] o_grant_count
`endif
);

  logic [0:4][0:4] req_m;
  logic [0:4][0:4] sel;
  logic            seen;

  port_vec_t    col_req [N_PORTS];
  port_vec_t    arb_gnt [N_PORTS];
  logic [2:0]   arb_win [N_PORTS];
  logic         arb_vld [N_PORTS];

  alloc_state_e state_q [N_PORTS];
  alloc_state_e state_d [N_PORTS];
  logic [2:0]   owner_q [N_PORTS];
  logic [2:0]   owner_d [N_PORTS];
  logic [2:0]   ptr_q   [N_PORTS];
  logic [2:0]   ptr_d   [N_PORTS];

  // Multi-hot requests collapse to the lowest index (c first).
  always_comb begin
    req_m = '0;
    seen  = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      seen = 1'b0;
      for (int j = 0; j < N_PORTS; j++) begin
        req_m[i][j] = i_output_req[i][j] & ~seen;
        seen        = seen | i_output_req[i][j];
      end
    end
  end

  always_comb begin
    for (int j = 0; j < N_PORTS; j++) begin
      col_req[j] = '0;
      for (int i = 0; i < N_PORTS; i++)
        col_req[j][i] = req_m[i][j];
    end
  end

  for (genvar g = 0; g < N_PORTS; g++) begin : g_arb
    mesh_rr_arbiter u_arb (
      .req    (col_req[g]),
      .ptr    (ptr_q[g]),
      .gnt    (arb_gnt[g]),
      .winner (arb_win[g]),
      .valid  (arb_vld[g])
    );
  end

  always_comb begin
    sel = '0;
    for (int j = 0; j < N_PORTS; j++) begin
      state_d[j] = state_q[j];
      owner_d[j] = owner_q[j];
      ptr_d[j]   = ptr_q[j];
      unique case (state_q[j])
        ALLOC_IDLE: begin
          if (i_output_en[j] && arb_vld[j]) begin
            sel[j]     = arb_gnt[j];
            ptr_d[j]   = next_port(arb_win[j]);
            owner_d[j] = arb_win[j];
            state_d[j] = i_tail[arb_win[j]] ?
                         ALLOC_IDLE : ALLOC_BUSY;
          end
        end
        ALLOC_BUSY: begin
          // Only the owner may move; the lock holds through bubbles.
          if (req_m[owner_q[j]][j] && i_output_en[j]) begin
            sel[j][owner_q[j]] = 1'b1;
            if (i_tail[owner_q[j]]) state_d[j] = ALLOC_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_xbar_sel    = reset ? '0 : sel;
    o_input_grant = '0;
    for (int j = 0; j < N_PORTS; j++)
      for (int i = 0; i < N_PORTS; i++)
        o_input_grant[i] = o_input_grant[i] | o_xbar_sel[j][i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < N_PORTS; j++) begin
        state_q[j] <= ALLOC_IDLE;
        owner_q[j] <= '0;
        ptr_q[j]   <= '0;
      end
    end else begin
      for (int j = 0; j < N_PORTS; j++) begin
        state_q[j] <= state_d[j];
        owner_q[j] <= owner_d[j];
        ptr_q[j]   <= ptr_d[j];
      end
    end
  end

`ifdef MESH_ALLOC_STATS_EN
  logic [STAT_WIDTH-1:0] cnt_q [N_PORTS];
  logic [STAT_WIDTH-1:0] cnt_d [N_PORTS];

  always_comb begin
    for (int j = 0; j < N_PORTS; j++) begin
      cnt_d[j]         = cnt_q[j] + STAT_WIDTH'(|sel[j]);
      o_grant_count[j] = cnt_q[j];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < N_PORTS; j++) cnt_q[j] <= '0;
    end else begin
      for (int j = 0; j < N_PORTS; j++) cnt_q[j] <= cnt_d[j];
    end
  end
`endif

endmodule

// File: tb/tb_mesh_switch_allocator.sv
// Random-traffic bench for mesh_switch_allocator against a
// packet-level reference model, plus directed literal cases.
module tb_mesh_switch_allocator;

  logic            clk = 1'b0;
  logic            reset;
  logic [0:4][0:4] req;
  logic [0:4]      tail;
  logic [0:4]      en;
  logic [0:4]      grant;
  logic [0:4][0:4] sel;
`ifdef MESH_ALLOC_STATS_EN
  logic [0:4][15:0] cnt;
`endif

  mesh_switch_allocator #(.STAT_WIDTH(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_output_req  (req),
    .i_tail        (tail),
    .i_output_en   (en),
    .o_input_grant (grant),
    .o_xbar_sel    (sel)
`ifdef MESH_ALLOC_STATS_EN
    ,
    .o_grant_count (cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int m_busy  [5];
  int m_owner [5];
  int m_ptr   [5];
  int m_cnt   [5];

  logic [0:4][0:4] e_sel;
  logic [0:4]      e_grant;

  int         pk_rem  [5];
  int         pk_dst  [5];
  logic [0:4] pk_mask [5];

  function automatic int tgt(input int i);
    for (int j = 0; j < 5; j++)
      if (req[i][j]) return j;
    return -1;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_eval();
    int o;
    int i;
    e_sel = '0;
    if (!reset) begin
      for (int j = 0; j < 5; j++) begin
        if (m_busy[j] != 0) begin
          o = m_owner[j];
          if (tgt(o) == j && en[j]) e_sel[j][o] = 1'b1;
        end else if (en[j]) begin
          for (int k = 0; k < 5; k++) begin
            i = (m_ptr[j] + k) % 5;
            if (tgt(i) == j) begin
              e_sel[j][i] = 1'b1;
              break;
            end
          end
        end
      end
    end
    e_grant = '0;
    for (int j = 0; j < 5; j++)
      for (int ii = 0; ii < 5; ii++)
        if (e_sel[j][ii]) e_grant[ii] = 1'b1;
  endtask

  task automatic model_step();
    for (int j = 0; j < 5; j++) begin
      if (reset) begin
        m_busy[j] = 0; m_owner[j] = 0;
        m_ptr[j] = 0;  m_cnt[j] = 0;
      end else if (e_sel[j] != 5'b0) begin
        for (int w = 0; w < 5; w++) begin
          if (e_sel[j][w]) begin
            if (m_busy[j] == 0) begin
              m_ptr[j]   = (w + 1) % 5;
              m_owner[j] = w;
              m_busy[j]  = tail[w] ? 0 : 1;
            end else if (tail[w]) begin
              m_busy[j] = 0;
            end
          end
        end
        m_cnt[j] = (m_cnt[j] + 1) % 65536;
      end
    end
  endtask

  task automatic compare_all();
    check("grant", 32'(grant), 32'(e_grant));
    for (int j = 0; j < 5; j++)
      check($sformatf("sel[%0d]", j), 32'(sel[j]), 32'(e_sel[j]));
`ifdef MESH_ALLOC_STATS_EN
    for (int j = 0; j < 5; j++)
      check($sformatf("cnt[%0d]", j), 32'(cnt[j]), 32'(m_cnt[j]));
`endif
  endtask

  task automatic settle();
    #1;
    model_eval();
    compare_all();
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    tail  = '0;
    en    = '0;
    for (int j = 0; j < 5; j++) begin
      m_busy[j] = 0; m_owner[j] = 0; m_ptr[j] = 0; m_cnt[j] = 0;
      pk_rem[j] = 0; pk_dst[j] = 0; pk_mask[j] = '0;
    end
    @(negedge clk);
    en = '1;
    req[1] = 5'b00100;
    settle();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_selE", 32'(sel[2]), 32'h0);
    advance();
    reset = 1'b0;

    // Single-flit to E from input 1
    req = '0; tail = '1; en = '1;
    req[1] = 5'b00100;
    settle();
    check("t1_grant", 32'(grant), 32'(5'b01000));
    check("t1_selE", 32'(sel[2]), 32'(5'b01000));
    advance();

    // ptr[E]=2: inputs 0,3 contend -> 3 then 0
    req = '0;
    req[0] = 5'b00100;
    req[3] = 5'b00100;
    settle();
    check("t2_first", 32'(grant), 32'(5'b00010));
    advance();
    settle();
    check("t2_second", 32'(grant), 32'(5'b10000));
    advance();
    settle();
    check("t2_third", 32'(grant), 32'(5'b00010));
    advance();

    // Multi-hot request reduces to N
    req = '0;
    req[0] = 5'b01010;
    settle();
    check("t5_selN", 32'(sel[1]), 32'(5'b10000));
    check("t5_selS", 32'(sel[3]), 32'h0);
    advance();

    // Input 2 locks N; input 4 waits; bubble; reset frees lock
    req = '0;
    req[2] = 5'b01000; tail[2] = 1'b0;
    req[4] = 5'b01000; tail[4] = 1'b1;
    settle();
    check("t3_head", 32'(grant), 32'(5'b00100));
    advance();
    en[1] = 1'b0;
    settle();
    check("t4_bubble", 32'(grant), 32'h0);
    advance();
    en[1] = 1'b1;
    settle();
    check("t4_resume", 32'(grant), 32'(5'b00100));
    advance();
    reset = 1'b1;
    settle();
    check("t6_rst", 32'(grant), 32'h0);
    advance();
    reset = 1'b0;
    req[2] = 5'b00000;
    settle();
    check("t6_idle", 32'(grant), 32'(5'b00001));
    advance();
`ifdef MESH_ALLOC_STATS_EN
    check("t6_cnt", 32'(cnt[1]), 32'h1);
`endif

    // Randomized packet traffic
    req = '0; tail = '0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 5; i++) begin
        if (pk_rem[i] == 0 && $urandom_range(2) == 0) begin
          pk_dst[i]  = $urandom_range(4);
          pk_rem[i]  = 1 + $urandom_range(3);
          pk_mask[i] = '0;
          pk_mask[i][pk_dst[i]] = 1'b1;
          if ($urandom_range(3) == 0)
            for (int jj = pk_dst[i] + 1; jj < 5; jj++)
              if ($urandom_range(1) == 1) pk_mask[i][jj] = 1'b1;
        end
        req[i]  = (pk_rem[i] != 0) ? pk_mask[i] : 5'b0;
        tail[i] = (pk_rem[i] != 0) ? (pk_rem[i] == 1)
                                   : 1'($urandom_range(1));
      end
      for (int j = 0; j < 5; j++)
        en[j] = ($urandom_range(4) != 0);
      reset = ($urandom_range(299) == 0);
      settle();
      for (int i = 0; i < 5; i++)
        if (e_grant[i]) pk_rem[i]--;
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
